// File: rtl/fifo_word_reader_if.sv
// rtl/fifo_word_reader_if.sv - byte FIFO read port and packed word output handshake
interface fifo_word_reader_if #(
   parameter int BYTES = 4
);
   logic               rready;
   logic               re;
   logic [7:0]         rdata;
   logic               word_valid;
   logic               word_ready;
   logic [BYTES*8-1:0] word_data;
   logic [3:0]         word_bytes;

   // master: the word reader; slave: FIFO plus word consumer
   modport master (
      input  rready,
      output re,
      input  rdata,
      output word_valid,
      input  word_ready,
      output word_data,
      output word_bytes
   );

   modport slave (
      output rready,
      input  re,
      output rdata,
      input  word_valid,
      output word_ready,
      input  word_data,
      input  word_bytes
   );
endinterface

// File: rtl/fifo_word_reader.sv
// rtl/fifo_word_reader.sv - pops FIFO bytes and packs them little-endian into words
module fifo_word_reader #(
   parameter int BYTES = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   fifo_word_reader_if.master  bus,
   input  logic                flush,
   output logic                busy,
   output logic [CNT_W-1:0]    byte_total
);

   typedef enum logic {FILL, HOLD} state_t;

   state_t             state, state_n;
   logic [3:0]         cnt, cnt_n, cnt_inc;
   logic [BYTES*8-1:0] shadow, shadow_n;
   logic [3:0]         nbytes, nbytes_n;
   logic [CNT_W-1:0]   total_n;
   logic               pop;

   // Popping is gated by reset so the FIFO never loses a byte while we are held in reset.
   assign bus.re  = rst & bus.rready & (state == FILL);
   assign pop     = bus.re;
   assign cnt_inc = cnt + 4'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      shadow_n = shadow;
      nbytes_n = nbytes;
      total_n  = byte_total;
      case (state)
         FILL: begin
            if (pop) begin
               for (int i = 0; i < BYTES; i++) begin
                  if (cnt == 4'(i)) begin
                     shadow_n[i*8 +: 8] = bus.rdata;
                  end
               end
               cnt_n   = cnt_inc;
               total_n = byte_total + CNT_W'(1);
            end
            // A byte popped in the flush cycle belongs to the flushed word.
            if (pop && (cnt_inc == 4'(BYTES))) begin
               state_n  = HOLD;
               nbytes_n = cnt_inc;
               cnt_n    = 4'd0;
            end else if (flush && ((cnt != 4'd0) || pop)) begin
               state_n  = HOLD;
               nbytes_n = pop ? cnt_inc : cnt;
               cnt_n    = 4'd0;
            end
         end
         HOLD: begin
            if (bus.word_ready) begin
               state_n  = FILL;
               shadow_n = '0;
               nbytes_n = 4'd0;
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= 4'd0;
         shadow     <= '0;
         nbytes     <= 4'd0;
         byte_total <= '0;
      end else begin
         cnt        <= cnt_n;
         shadow     <= shadow_n;
         nbytes     <= nbytes_n;
         byte_total <= total_n;
      end
   end

   assign bus.word_valid = (state == HOLD);
   assign bus.word_data  = shadow;
   assign bus.word_bytes = nbytes;
   assign busy           = (cnt != 4'd0) | bus.word_valid;

endmodule

// File: doc/fifo_word_reader.md
Name: fifo_word_reader

Overview:
Consumer-side client for the team's byte FIFO read port (re / rready / rdata). It pops bytes from the FIFO and packs them little-endian into BYTES-wide words. Completed words are presented on a valid/ready output handshake. It sits between the FIFO bank and 32-bit consumers such as the bus bridge and the result uploader, and supports a flush that emits a partially filled word.

Parameters:
BYTES, 4, bytes per output word (2..8)
CNT_W, 16, width of the popped-byte statistics counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
rready  input  1  FIFO has a byte available (FIFO not empty)
re  output  1  pop request to FIFO
rdata  input  8  FIFO read data, valid combinationally in the same cycle as re
flush  input  1  emit the partial word (level-sampled)
word_valid  output  1  output word available
word_ready  input  1  consumer accepts word
word_data  output  BYTES*8  packed word; byte 0 at [7:0]
word_bytes  output  4  number of valid bytes in word_data (1..BYTES)
busy  output  1  partial word held (byte count > 0) or word_valid high
byte_total  output  CNT_W  total bytes popped since reset; wraps

Behaviour:
- Reset (rst=0, asynchronous): state=FILL, cnt=0, word_valid=0, word_data=0, word_bytes=0, byte_total=0. While rst=0, re is forced to 0.
- Pop rule: a byte is consumed on the rising edge where re=1 and rready=1. re is combinational: re = rst & rready & (state==FILL). re is never 1 while rready=0.
- FILL state, on a pop:
  - rdata is written to byte lane cnt of the shadow word; cnt++; byte_total++ (mod 2^CNT_W).
  - If the new cnt == BYTES: go to HOLD, word_valid=1, word_bytes=BYTES, cnt=0.
- FILL state, flush=1:
  - If cnt>0 or a pop occurs in the same cycle, go to HOLD with word_bytes = cnt plus the popped byte, if any.
  - A byte popped in the flush cycle is included in the flushed word.
  - If cnt==0 and no pop occurs, flush is ignored and no empty word is ever emitted.
- Unfilled lanes of an emitted word are 0.
- HOLD state:
  - word_valid=1; word_data and word_bytes are stable; re=0; flush is ignored.
  - On word_valid & word_ready: word_valid=0, shadow cleared to 0, return to FILL.
  - The earliest next pop is the following cycle, giving one bubble per word.
- Latency: with rready and word_ready held high, word_valid rises on the edge of the BYTES-th pop. Throughput is BYTES bytes per BYTES+1 cycles.
- rready gaps: cnt holds and no byte is lost or duplicated.
- Reset mid-word or during HOLD: the partial or held word is discarded and outputs return to their reset values. Bytes already popped are not returned to the FIFO.
- busy = (cnt!=0) | word_valid.

Test Plan:
- BYTES=4; rready=1, rdata sequence 0x11,0x22,0x33,0x44; word_ready=1 -> re high for 4 cycles. word_valid for 1 cycle with word_data=0x44332211, word_bytes=4. re=0 during that cycle. byte_total=4.
- Same stream with word_ready=0 for 5 cycles after valid -> word_data is held stable, re stays 0, and no further pops occur. After word_ready=1, the next 4 bytes 0x55..0x88 produce 0x88776655.
- Pop 0xA1,0xB2, then rready=0 and flush=1 -> word_data=0x0000B2A1, word_bytes=2. The next word starts at lane 0.
- flush=1 on the same cycle as the 3rd pop 0xC3, after 0xA1,0xB2 -> word_bytes=3, word_data=0x00C3B2A1.
- flush=1 with cnt=0 and rready=0 -> no word_valid, busy=0. rready toggling 1,0,1,0 with 4 bytes -> exactly 4 pops and one correct word.
- Assert rst=0 asynchronously after 2 pops -> outputs return to reset values immediately and re=0. After release, 4 new bytes form a word with no residue from the earlier pops; byte_total counts only post-reset pops (4).
